sha256_digest_reader: RTL and testbench

SHA256_DIGEST_READER -- requirements
Module: sha256_digest_reader

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_digest_reader_clz32.sv | 15 +
 rtl/sha256_digest_reader.sv | 84 ++++++++
 tb/tb_sha256_digest_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the digest readout path.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned NUM_WORDS = 8;

  localparam word_t H0 = 32'h6a09e667;
  localparam word_t H1 = 32'hbb67ae85;
  localparam word_t H2 = 32'h3c6ef372;
  localparam word_t H3 = 32'ha54ff53a;
  localparam word_t H4 = 32'h510e527f;
  localparam word_t H5 = 32'h9b05688c;
  localparam word_t H6 = 32'h1f83d9ab;
  localparam word_t H7 = 32'h5be0cd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic word_t bswap32(input word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_digest_reader_clz32.sv
// Combinational leading-zero count of a 32-bit word; 32 for an all-zero word.
module clz32 (
  input  logic [31:0] word,
  output logic [5:0]  count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (word[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/sha256_digest_reader.sv
// Captures a 256-bit SHA-256 digest and streams it out as eight 32-bit words,
// counting the digest's leading zero bits along the way.
module sha256_digest_reader
  import sha256_pkg::*;
#(
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         digest_valid,
  output logic         digest_ready,
  input  logic [255:0] h_in,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [2:0]   word_index,
  output logic         word_last,
  output logic [8:0]   lz_count,
  output logic         lz_valid
);

  state_t                          state;
  logic [NUM_WORDS-1:0][31:0]      words;
  logic [2:0]                      idx;
  logic [8:0]                      acc;
  logic                            counting;
  word_t                           cur;
  logic [5:0]                      cur_clz;

  // words[7] holds H0, so word index k lives at words[~k].
  assign cur = words[~idx];

  clz32 u_clz (
    .word  (cur),
    .count (cur_clz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      words    <= '0;
      idx      <= '0;
      acc      <= '0;
      counting <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (digest_valid) begin
            words    <= h_in;
            idx      <= '0;
            acc      <= '0;
            counting <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (word_ready) begin
            // A zero word adds 32 and keeps counting; the first nonzero word ends it.
            if (counting) begin
              acc      <= acc + 9'(cur_clz);
              counting <= (cur == '0);
            end
            if (idx == 3'd7) state <= DONE;
            else             idx   <= idx + 3'd1;
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digest_ready = (state == IDLE);
  assign word_valid   = (state == SEND);
  assign word_out     = (state != SEND) ? '0 : (BYTE_SWAP ? bswap32(cur) : cur);
  assign word_index   = idx;
  assign word_last    = (state == SEND) && (idx == 3'd7);
  assign lz_count     = acc;
  assign lz_valid     = (state == DONE);

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed bench for sha256_digest_reader: one plain and one byte-swapping instance.
module tb_sha256_digest_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         digest_valid;
  logic [255:0] h_in;
  logic         word_ready;

  logic        dr0, wv0, wl0, lv0;
  logic [31:0] wo0;
  logic [2:0]  wi0;
  logic [8:0]  lc0;
  logic        dr1, wv1, wl1, lv1;
  logic [31:0] wo1;
  logic [2:0]  wi1;
  logic [8:0]  lc1;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ZERO = '0;
  localparam logic [255:0] LZ60 =
    256'h00000000_0000000f_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [255:0] LZ60Z =
    256'h00000000_0000000f_00000000_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [255:0] LZ8 =
    256'h00ff0000_00000000_12345678_9abcdef0_00000000_00000001_80000000_00000000;

  always #5 clk = ~clk;

  always @(posedge clk) if (lv0) pulses <= pulses + 1;

  sha256_digest_reader #(.BYTE_SWAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .digest_valid(digest_valid), .digest_ready(dr0),
    .h_in(h_in), .word_out(wo0), .word_valid(wv0), .word_ready(word_ready),
    .word_index(wi0), .word_last(wl0), .lz_count(lc0), .lz_valid(lv0)
  );

  sha256_digest_reader #(.BYTE_SWAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .digest_valid(digest_valid), .digest_ready(dr1),
    .h_in(h_in), .word_out(wo1), .word_valid(wv1), .word_ready(word_ready),
    .word_index(wi1), .word_last(wl1), .lz_count(lc1), .lz_valid(lv1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wsel(input logic [255:0] h, input int k);
    return h[255 - 32*k -: 32];
  endfunction

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // stall_at: hold word_ready low 3 cycles at that index; poke_at: assert digest_valid there.
  task automatic run_stream(input string tag, input logic [255:0] h, input logic [8:0] exp_lz,
                            input int stall_at, input int poke_at);
    chk({tag, " ready"}, 32'(dr0), 32'd1);
    digest_valid = 1'b1;
    h_in         = h;
    word_ready   = 1'b1;
    tick();
    digest_valid = 1'b0;
    h_in         = '0;
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        word_ready = 1'b0;
        repeat (3) begin
          tick();
          chk($sformatf("%s stall valid", tag), 32'(wv0), 32'd1);
          chk($sformatf("%s stall idx", tag), 32'(wi0), 32'(k));
          chk($sformatf("%s stall word", tag), wo0, wsel(h, k));
        end
        word_ready = 1'b1;
      end
      if (k == poke_at) begin
        digest_valid = 1'b1;
        h_in         = ~h;
      end
      chk($sformatf("%s w%0d valid", tag, k), 32'(wv0), 32'd1);
      chk($sformatf("%s w%0d ready", tag, k), 32'(dr0), 32'd0);
      chk($sformatf("%s w%0d idx", tag, k), 32'(wi0), 32'(k));
      chk($sformatf("%s w%0d word", tag, k), wo0, wsel(h, k));
      chk($sformatf("%s w%0d swapped", tag, k), wo1, swap(wsel(h, k)));
      chk($sformatf("%s w%0d last", tag, k), 32'(wl0), (k == 7) ? 32'd1 : 32'd0);
      tick();
      digest_valid = 1'b0;
      h_in         = '0;
    end
    chk({tag, " lz_valid"}, 32'(lv0), 32'd1);
    chk({tag, " lz_count"}, 32'(lc0), 32'(exp_lz));
    chk({tag, " lz_valid swap"}, 32'(lv1), 32'd1);
    chk({tag, " lz_count swap"}, 32'(lc1), 32'(exp_lz));
    chk({tag, " done valid"}, 32'(wv0), 32'd0);
    tick();
    chk({tag, " lz pulse end"}, 32'(lv0), 32'd0);
    chk({tag, " lz hold"}, 32'(lc0), 32'(exp_lz));
    chk({tag, " back idle"}, 32'(dr0), 32'd1);
  endtask

  initial begin
    int p;
    rst          = 1'b1;
    digest_valid = 1'b0;
    h_in         = '0;
    word_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst ready", 32'(dr0), 32'd1);
    chk("rst valid", 32'(wv0), 32'd0);
    chk("rst last", 32'(wl0), 32'd0);
    chk("rst word", wo0, 32'd0);
    chk("rst idx", 32'(wi0), 32'd0);
    chk("rst lz", 32'(lc0), 32'd0);
    chk("rst lzv", 32'(lv0), 32'd0);

    run_stream("abc", ABC, 9'd0, -1, -1);
    chk("abc pulses", 32'(pulses), 32'd1);
    run_stream("zero", ZERO, 9'd256, -1, -1);
    run_stream("lz60", LZ60, 9'd60, -1, -1);
    run_stream("lz60z", LZ60Z, 9'd60, -1, -1);
    run_stream("lz8", LZ8, 9'd8, -1, -1);
    run_stream("stall", ABC, 9'd0, 2, -1);
    run_stream("poke", ABC, 9'd0, -1, 3);

    // Reset in the middle of a stream.
    digest_valid = 1'b1;
    h_in         = LZ60;
    word_ready   = 1'b1;
    tick();
    digest_valid = 1'b0;
    repeat (4) tick();
    chk("abort at idx", 32'(wi0), 32'd4);
    p   = pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort ready", 32'(dr0), 32'd1);
    chk("abort valid", 32'(wv0), 32'd0);
    chk("abort last", 32'(wl0), 32'd0);
    chk("abort idx", 32'(wi0), 32'd0);
    chk("abort word", wo0, 32'd0);
    chk("abort lz", 32'(lc0), 32'd0);
    repeat (3) tick();
    chk("abort no pulse", 32'(pulses), 32'(p));

    // Reset wins over a simultaneous capture request.
    rst          = 1'b1;
    digest_valid = 1'b1;
    h_in         = ABC;
    tick();
    rst          = 1'b0;
    digest_valid = 1'b0;
    chk("rst prio ready", 32'(dr0), 32'd1);
    chk("rst prio valid", 32'(wv0), 32'd0);

    run_stream("after abort", LZ60Z, 9'd60, 5, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
